rsa_operand_loader: RTL

// - Upstream feeder for mon_exp. Accepts a 32-bit host word stream carrying X_bar and M_bar.
// - Packs the stream into 512-bit halves and writes them through bram write port 2.
// - Pulses mon_exp start, waits for stop, then captures ans into a held result register.
// - e, e_idx, M and mp_count still come straight from the host. This block does not touch them.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/rsa_word_packer.sv | 34 +++
 rtl/rsa_operand_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared widths, framing constants and loader FSM encoding for the RSA operand loader.
package rsa_pkg;

    localparam int unsigned WBITS          = 32;
    localparam int unsigned DBITS          = 512;
    localparam int unsigned ABITS          = 8;
    localparam int unsigned bitLen         = 1024;
    localparam int unsigned WORDS_PER_HALF = DBITS / WBITS;
    localparam int unsigned NUM_HALVES     = 4;
    localparam int unsigned CNT_BITS       = $clog2(WORDS_PER_HALF);
    localparam int unsigned HALF_BITS      = $clog2(NUM_HALVES);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StStart,
        StWait,
        StDone
    } ldr_state_e;

endpackage

// File: rtl/rsa_word_packer.sv
// Little-endian word packer: shifts host words into a DBITS register and flags the
// transfer that completes a half.
module rsa_word_packer
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic [WBITS-1:0] in_data,
    output logic [DBITS-1:0] sr,
    output logic             full
);

    localparam logic [CNT_BITS-1:0] LastCnt = CNT_BITS'(WORDS_PER_HALF - 1);

    logic [CNT_BITS-1:0] word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            word_cnt <= '0;
        end else if (clear) begin
            sr       <= '0;
            word_cnt <= '0;
        end else if (shift) begin
            sr       <= {in_data, sr[DBITS-1:WBITS]};
            word_cnt <= (word_cnt == LastCnt) ? '0 : word_cnt + CNT_BITS'(1);
        end
    end

    assign full = shift && (word_cnt == LastCnt);

endmodule

// File: rtl/rsa_operand_loader.sv
// Streams X_bar/M_bar into bram port 2, kicks mon_exp and captures its answer.
// Optional framing check on in_last/err when LDR_LAST_CHECK_EN is defined.
module rsa_operand_loader
    import rsa_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WBITS-1:0]  in_data,
`ifdef LDR_LAST_CHECK_EN
    input  logic              in_last,
    output logic              err,
`endif
    output logic [ABITS-1:0]  wr_addr2,
    output logic [DBITS-1:0]  wr_data2,
    output logic              wr_en2,
    output logic              me_start,
    input  logic              me_stop,
    input  logic [bitLen:0]   me_ans,
    output logic              busy,
    output logic              done,
    output logic [bitLen:0]   res
);

    localparam logic [ABITS-1:0]     BaseAddr = ABITS'(BASE_ADDR);
    localparam logic [HALF_BITS-1:0] LastHalf = HALF_BITS'(NUM_HALVES - 1);

    ldr_state_e           state_q, state_d;
    logic [HALF_BITS-1:0] half_q, half_d;
    logic [bitLen:0]      res_q, res_d;
    logic                 err_q, err_d;
    logic                 stop_q;
    logic                 stop_rise;
    logic                 xfer;
    logic                 full;
    logic [DBITS-1:0]     sr;

    assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
    assign xfer      = in_valid && in_ready;
    assign stop_rise = me_stop && !stop_q;

    rsa_word_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .shift   (xfer && !clear),
        .in_data (in_data),
        .sr      (sr),
        .full    (full)
    );

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        res_d    = res_q;
        err_d    = err_q;
        wr_en2   = 1'b0;
        wr_addr2 = '0;
        wr_data2 = '0;
        me_start = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (xfer) state_d = full ? StWrite : StLoad;
            end
            StLoad: begin
                if (full) state_d = StWrite;
            end
            StWrite: begin
                wr_en2   = 1'b1;
                wr_addr2 = BaseAddr + ABITS'(half_q);
                wr_data2 = sr;
                half_d   = half_q + HALF_BITS'(1);
                if (half_q == LastHalf) begin
                    // A framing error aborts before mon_exp is ever started.
                    state_d = err_q ? StIdle : StStart;
                end else begin
                    state_d = StLoad;
                end
            end
            StStart: begin
                me_start = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (stop_rise) begin
                    res_d   = me_ans;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                half_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef LDR_LAST_CHECK_EN
        // in_last must coincide exactly with the final word of the last half.
        if (xfer && (in_last != (full && (half_q == LastHalf)))) err_d = 1'b1;
`endif

        if (clear) begin
            state_d = StIdle;
            half_d  = '0;
            res_d   = res_q;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            half_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            res_q   <= res_d;
            err_q   <= err_d;
            stop_q  <= me_stop;
        end
    end

    assign busy = (state_q != StIdle);
    assign res  = res_q;
`ifdef LDR_LAST_CHECK_EN
    assign err  = err_q;
`endif

endmodule
